// File: rtl/fifo_ctrl_vc1_pkg.sv
// Shared types and defaults for the VC1 queue controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fifo_vc1_pkg;

    // Default geometry: 8-entry queue.
    localparam int ADDR_WIDTH_DEF      = 3;
    localparam int DEPTH_DEF           = 2 ** ADDR_WIDTH_DEF;
    localparam int ALMOST_FULL_TH_DEF  = 6;
    localparam int ALMOST_EMPTY_TH_DEF = 2;

    // Controller state. Plain constants keep the encoding stable for
    // older tools and for anything that probes the raw state bits.
    typedef logic [1:0] state_t;

    localparam state_t ST_EMPTY  = 2'd0;
    localparam state_t ST_ACTIVE = 2'd1;
    localparam state_t ST_FULL   = 2'd2;
    localparam state_t ST_ERROR  = 2'd3;

endpackage

// File: rtl/fifo_ctrl_vc1_if.sv
// Request/status bundle between the VC1 queue controller and its users.
// Latency: n/a (wires only).
// Backpressure: full/almost flags tell the writer to stop; empty tells the reader.
interface fifo_ctrl_vc1_if #(
    parameter int ADDR_WIDTH = fifo_vc1_pkg::ADDR_WIDTH_DEF
);
    // Requests from writer / reader
    logic                  push;
    logic                  pop;
    logic                  err_clr;

    // RAM control
    logic                  wr_en;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;

    // Occupancy and status
    logic [ADDR_WIDTH:0]   count;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  overflow_err;
    logic                  underflow_err;

    // Requester side
    modport master (
        output push, pop, err_clr,
        input  wr_en, rd_en, wr_ptr, rd_ptr, count,
        input  full, empty, almost_full, almost_empty,
        input  overflow_err, underflow_err
    );

    // Controller side
    modport slave (
        input  push, pop, err_clr,
        output wr_en, rd_en, wr_ptr, rd_ptr, count,
        output full, empty, almost_full, almost_empty,
        output overflow_err, underflow_err
    );

endinterface

// File: rtl/fifo_ctrl_vc1_ptr.sv
// Wrap-bit pointer: counts 0..2*depth-1, MSB toggles each pass over the RAM.
// Latency: one cycle from en_i to the advanced pointer.
// Backpressure: none; advances whenever en_i is high.
module ptr_counter_vc1 #(
    parameter int W = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    output logic [W:0] ptr_o
);

    logic [W:0] ptr_q;
    logic [W:0] ptr_d;

    // Next pointer: natural overflow of the W+1 bit value toggles the wrap bit.
    always_comb begin
        ptr_d = ptr_q;
        if (en_i) begin
            ptr_d = ptr_q + {{W{1'b0}}, 1'b1};
        end
    end

    // Pointer register, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_ctrl_vc1.sv
// VC1 queue control: pointers, occupancy, flags and sticky over/underflow for an external RAM.
// Latency: wr_en/rd_en are combinational; pointers/count/flags/errors update on the accepting edge.
// Backpressure: push is refused when full unless a pop drains in the same cycle; pop is refused when empty.
module fifo_ctrl_vc1
    import fifo_vc1_pkg::*;
#(
    parameter int ADDR_WIDTH      = ADDR_WIDTH_DEF,
    parameter int ALMOST_FULL_TH  = ALMOST_FULL_TH_DEF,
    parameter int ALMOST_EMPTY_TH = ALMOST_EMPTY_TH_DEF
) (
    input  logic          clk,
    input  logic          reset,
    fifo_ctrl_vc1_if.slave bus
);

    localparam int AW = ADDR_WIDTH;

    localparam logic [AW:0] DEPTH_C = (AW + 1)'(2 ** AW);
    localparam logic [AW:0] AF_TH   = (AW + 1)'(ALMOST_FULL_TH);
    localparam logic [AW:0] AE_TH   = (AW + 1)'(ALMOST_EMPTY_TH);

    logic [AW:0] wr_ptr_full;
    logic [AW:0] rd_ptr_full;
    logic [AW:0] count_w;
    logic [AW:0] cnt_nxt;

    logic        full_w;
    logic        empty_w;
    logic        full_eff;
    logic        wr_acc;
    logic        rd_acc;
    logic        ovf_new;
    logic        unf_new;
    logic        err_new;

    logic        ovf_q;
    logic        ovf_d;
    logic        unf_q;
    logic        unf_d;

    state_t      state_q;
    state_t      state_d;
    state_t      state_cnt;

    // Write and read pointers, each with a wrap bit above the RAM address.
    ptr_counter_vc1 #(.W(AW)) u_wr_ptr (
        .clk   (clk),
        .rst   (reset),
        .en_i  (wr_acc),
        .ptr_o (wr_ptr_full)
    );

    ptr_counter_vc1 #(.W(AW)) u_rd_ptr (
        .clk   (clk),
        .rst   (reset),
        .en_i  (rd_acc),
        .ptr_o (rd_ptr_full)
    );

    // Same slot with opposite wrap bits means the writer has lapped the reader.
    assign full_w  = (wr_ptr_full[AW-1:0] == rd_ptr_full[AW-1:0]) &&
                     (wr_ptr_full[AW] != rd_ptr_full[AW]);
    assign empty_w = (wr_ptr_full == rd_ptr_full);
    assign count_w = wr_ptr_full - rd_ptr_full;

    // A full queue still takes a push if a pop frees a slot on the same edge.
    // There is no empty bypass: a pop against an empty queue is always refused.
    assign full_eff = full_w & ~(bus.pop & ~empty_w);
    assign wr_acc   = bus.push & ~full_eff;
    assign rd_acc   = bus.pop & ~empty_w;
    assign ovf_new  = bus.push & ~wr_acc;
    assign unf_new  = bus.pop & ~rd_acc;
    assign err_new  = ovf_new | unf_new;

    // Occupancy after this edge and the non-error state that matches it.
    always_comb begin
        cnt_nxt = count_w;
        if (wr_acc && !rd_acc) begin
            cnt_nxt = count_w + {{AW{1'b0}}, 1'b1};
        end else if (rd_acc && !wr_acc) begin
            cnt_nxt = count_w - {{AW{1'b0}}, 1'b1};
        end

        state_cnt = ST_ACTIVE;
        if (cnt_nxt == '0) begin
            state_cnt = ST_EMPTY;
        end else if (cnt_nxt == DEPTH_C) begin
            state_cnt = ST_FULL;
        end
    end

    // Sticky errors: a fresh error always wins over a clear in the same cycle.
    always_comb begin
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (err_new) begin
            ovf_d = ovf_q | ovf_new;
            unf_d = unf_q | unf_new;
        end else if (bus.err_clr) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
    end

    // State transitions; any refused request forces ERROR.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (wr_acc) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (cnt_nxt == DEPTH_C) begin
                    state_d = ST_FULL;
                end else if (cnt_nxt == '0) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (rd_acc && !wr_acc) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ERROR: begin
                if (bus.err_clr) begin
                    state_d = state_cnt;
                end
            end
            default: begin
                state_d = ST_ERROR;
            end
        endcase
        if (err_new) begin
            state_d = ST_ERROR;
        end
    end

    // State and error registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Enables are masked by reset so the RAM sees no write while it is held.
    assign bus.wr_en         = wr_acc & ~reset;
    assign bus.rd_en         = rd_acc & ~reset;
    assign bus.wr_ptr        = wr_ptr_full[AW-1:0];
    assign bus.rd_ptr        = rd_ptr_full[AW-1:0];
    assign bus.count         = count_w;
    assign bus.full          = full_w;
    assign bus.empty         = empty_w;
    assign bus.almost_full   = (count_w >= AF_TH);
    assign bus.almost_empty  = (count_w <= AE_TH);
    assign bus.overflow_err  = ovf_q;
    assign bus.underflow_err = unf_q;

endmodule

// File: tb/tb_fifo_ctrl_vc1.sv
// Directed bench for the VC1 queue controller with an expectation queue and a negedge monitor.
// Latency: each vector is one clock; expectations describe what is visible during that cycle.
// Backpressure: n/a (bench).
module tb_fifo_ctrl_vc1;

    logic clk;
    logic reset;

    fifo_ctrl_vc1_if #(.ADDR_WIDTH(3)) bus ();

    fifo_ctrl_vc1 #(
        .ADDR_WIDTH      (3),
        .ALMOST_FULL_TH  (6),
        .ALMOST_EMPTY_TH (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       we;
        logic       re;
        logic [2:0] wp;
        logic [2:0] rp;
        logic [3:0] cnt;
        logic       fu;
        logic       em;
        logic       af;
        logic       ae;
        logic       ov;
        logic       un;
        logic [1:0] st;
    } obs_t;

    typedef struct {
        string name;
        logic  push;
        logic  pop;
        logic  clr;
        logic  rst;
        obs_t  exp;
    } vec_t;

    typedef struct {
        string name;
        obs_t  exp;
    } chk_t;

    vec_t vecs[$];
    chk_t exp_q[$];

    int tests_run = 0;
    int tests_failed = 0;

    function automatic obs_t mk(input logic we, input logic re, input int wp, input int rp,
                                input int cnt, input logic fu, input logic em, input logic af,
                                input logic ae, input logic ov, input logic un, input int st);
        obs_t o;
        o.we  = we;
        o.re  = re;
        o.wp  = 3'(wp);
        o.rp  = 3'(rp);
        o.cnt = 4'(cnt);
        o.fu  = fu;
        o.em  = em;
        o.af  = af;
        o.ae  = ae;
        o.ov  = ov;
        o.un  = un;
        o.st  = 2'(st);
        return o;
    endfunction

    task automatic add(input string name, input logic p, input logic q, input logic c,
                       input logic r, input obs_t e);
        vec_t v;
        v.name = name;
        v.push = p;
        v.pop  = q;
        v.clr  = c;
        v.rst  = r;
        v.exp  = e;
        vecs.push_back(v);
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.we  = bus.wr_en;
        o.re  = bus.rd_en;
        o.wp  = bus.wr_ptr;
        o.rp  = bus.rd_ptr;
        o.cnt = bus.count;
        o.fu  = bus.full;
        o.em  = bus.empty;
        o.af  = bus.almost_full;
        o.ae  = bus.almost_empty;
        o.ov  = bus.overflow_err;
        o.un  = bus.underflow_err;
        o.st  = dut.state_q;
        return o;
    endfunction

    // Monitor: one expectation per cycle, compared on the falling edge.
    initial begin
        chk_t c;
        obs_t a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                c = exp_q.pop_front();
                a = sample();
                tests_run++;
                if (a !== c.exp) begin
                    tests_failed++;
                    $display("FAIL %s: got we=%b re=%b wp=%0d rp=%0d cnt=%0d fu=%b em=%b af=%b ae=%b ov=%b un=%b st=%0d, expected we=%b re=%b wp=%0d rp=%0d cnt=%0d fu=%b em=%b af=%b ae=%b ov=%b un=%b st=%0d",
                             c.name, a.we, a.re, a.wp, a.rp, a.cnt, a.fu, a.em, a.af, a.ae, a.ov, a.un, a.st,
                             c.exp.we, c.exp.re, c.exp.wp, c.exp.rp, c.exp.cnt, c.exp.fu, c.exp.em,
                             c.exp.af, c.exp.ae, c.exp.ov, c.exp.un, c.exp.st);
                end
            end
        end
    end

    // Driver: builds the directed table, then applies one vector per cycle.
    initial begin
        chk_t c;
        int   waited;

        //                       push pop clr rst    we re wp rp cnt fu em af ae ov un st
        add("reset_idle0",        0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
        add("reset_idle1",        0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
        add("push1",              1, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
        add("push2",              1, 0, 0, 0, mk(1, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 1));
        add("push3",              1, 0, 0, 0, mk(1, 0, 2, 0, 2, 0, 0, 0, 1, 0, 0, 1));
        add("push4",              1, 0, 0, 0, mk(1, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 1));
        add("push5",              1, 0, 0, 0, mk(1, 0, 4, 0, 4, 0, 0, 0, 0, 0, 0, 1));
        add("push6",              1, 0, 0, 0, mk(1, 0, 5, 0, 5, 0, 0, 0, 0, 0, 0, 1));
        add("push7_af",           1, 0, 0, 0, mk(1, 0, 6, 0, 6, 0, 0, 1, 0, 0, 0, 1));
        add("push8",              1, 0, 0, 0, mk(1, 0, 7, 0, 7, 0, 0, 1, 0, 0, 0, 1));
        add("full_wrap",          0, 0, 0, 0, mk(0, 0, 0, 0, 8, 1, 0, 1, 0, 0, 0, 2));
        add("full_pushpop",       1, 1, 0, 0, mk(1, 1, 0, 0, 8, 1, 0, 1, 0, 0, 0, 2));
        add("after_pushpop",      0, 0, 0, 0, mk(0, 0, 1, 1, 8, 1, 0, 1, 0, 0, 0, 2));
        add("push_when_full",     1, 0, 0, 0, mk(0, 0, 1, 1, 8, 1, 0, 1, 0, 0, 0, 2));
        add("overflow_error",     0, 0, 0, 0, mk(0, 0, 1, 1, 8, 1, 0, 1, 0, 1, 0, 3));
        add("err_clr_ovf",        0, 0, 1, 0, mk(0, 0, 1, 1, 8, 1, 0, 1, 0, 1, 0, 3));
        add("cleared_to_full",    0, 0, 0, 0, mk(0, 0, 1, 1, 8, 1, 0, 1, 0, 0, 0, 2));
        add("pop1",               0, 1, 0, 0, mk(0, 1, 1, 1, 8, 1, 0, 1, 0, 0, 0, 2));
        add("pop2",               0, 1, 0, 0, mk(0, 1, 1, 2, 7, 0, 0, 1, 0, 0, 0, 1));
        add("pop3",               0, 1, 0, 0, mk(0, 1, 1, 3, 6, 0, 0, 1, 0, 0, 0, 1));
        add("pop4",               0, 1, 0, 0, mk(0, 1, 1, 4, 5, 0, 0, 0, 0, 0, 0, 1));
        add("pop5",               0, 1, 0, 0, mk(0, 1, 1, 5, 4, 0, 0, 0, 0, 0, 0, 1));
        add("pop6",               0, 1, 0, 0, mk(0, 1, 1, 6, 3, 0, 0, 0, 0, 0, 0, 1));
        add("pop7_ae",            0, 1, 0, 0, mk(0, 1, 1, 7, 2, 0, 0, 0, 1, 0, 0, 1));
        add("pop8",               0, 1, 0, 0, mk(0, 1, 1, 0, 1, 0, 0, 0, 1, 0, 0, 1));
        add("drained_empty",      0, 0, 0, 0, mk(0, 0, 1, 1, 0, 0, 1, 0, 1, 0, 0, 0));
        add("pushpop_on_empty",   1, 1, 0, 0, mk(1, 0, 1, 1, 0, 0, 1, 0, 1, 0, 0, 0));
        add("underflow_error",    0, 0, 0, 0, mk(0, 0, 2, 1, 1, 0, 0, 0, 1, 0, 1, 3));
        add("err_clr_unf",        0, 0, 1, 0, mk(0, 0, 2, 1, 1, 0, 0, 0, 1, 0, 1, 3));
        add("cleared_to_active",  0, 0, 0, 0, mk(0, 0, 2, 1, 1, 0, 0, 0, 1, 0, 0, 1));
        add("fill_a",             1, 0, 0, 0, mk(1, 0, 2, 1, 1, 0, 0, 0, 1, 0, 0, 1));
        add("fill_b",             1, 0, 0, 0, mk(1, 0, 3, 1, 2, 0, 0, 0, 1, 0, 0, 1));
        add("fill_c",             1, 0, 0, 0, mk(1, 0, 4, 1, 3, 0, 0, 0, 0, 0, 0, 1));
        add("fill_d",             1, 0, 0, 0, mk(1, 0, 5, 1, 4, 0, 0, 0, 0, 0, 0, 1));
        add("count5",             0, 0, 0, 0, mk(0, 0, 6, 1, 5, 0, 0, 0, 0, 0, 0, 1));
        add("mid_cycle_reset",    1, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
        add("first_push_addr0",   1, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
        add("after_reset_push",   0, 0, 0, 0, mk(0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 1));

        reset       = 1'b1;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.err_clr = 1'b0;
        repeat (3) @(posedge clk);

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            reset       = vecs[i].rst;
            bus.push    = vecs[i].push;
            bus.pop     = vecs[i].pop;
            bus.err_clr = vecs[i].clr;
            c.name = vecs[i].name;
            c.exp  = vecs[i].exp;
            exp_q.push_back(c);
        end

        @(posedge clk);
        #1;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.err_clr = 1'b0;
        reset       = 1'b0;

        waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        if (exp_q.size() > 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain_timeout: %0d expectations left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
